dff_bank_arbiter: RTL and testbench

Shares a small bank of edge-triggered D flip-flop registers between two writers, A and B. A round-robin arbiter and a three-state write sequencer control the bank. The block sits one level above the D-FF cells: each granted request is latched into a holding register, then committed to the bank on the next edge, then acknowledged. A combinational read port exposes committed bank contents.

---
 rtl/dff_bank_arbiter.sv | 119 +++++++++++
 tb/tb_dff_bank_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
//
// Shares a small bank of D flip-flop registers between two writers, A and B.
// A round-robin arbiter picks a winner while the sequencer is idle. The
// winner's address/data are latched into a holding register, committed to
// the bank on the following edge, and then acknowledged with a done pulse.
// One write completes every three cycles.
//
// Ports:
//   Cp       - clock, all state updates on the rising edge
//   nCLR     - asynchronous active-low reset, clears everything incl. bank
//   reqA     - writer A request (held until gntA is seen)
//   addrA    - writer A target entry
//   dataA    - writer A write data
//   reqB     - writer B request (same rules as A)
//   addrB    - writer B target entry
//   dataB    - writer B write data
//   gntA     - registered one-cycle grant pulse to A
//   gntB     - registered one-cycle grant pulse to B
//   done     - registered one-cycle pulse, granted write has been committed
//   busy     - high whenever the sequencer is not idle
//   rd_addr  - read address
//   rd_data  - combinational read of the committed bank entry
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int AW    = 2
) (
  input  logic             Cp,
  input  logic             nCLR,
  input  logic             reqA,
  input  logic [AW-1:0]    addrA,
  input  logic [WIDTH-1:0] dataA,
  input  logic             reqB,
  input  logic [AW-1:0]    addrB,
  input  logic [WIDTH-1:0] dataB,
  output logic             gntA,
  output logic             gntB,
  output logic             done,
  output logic             busy,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    hold_addr;
  logic [WIDTH-1:0] hold_data;
  logic             last;
  logic [WIDTH-1:0] bank [DEPTH];

  logic any_req;
  logic win_b;

  // B wins when it is the only requester, or on a tie when A was served
  // last (last == 0). Otherwise A wins.
  assign any_req = reqA | reqB;
  assign win_b   = reqB & (~reqA | ~last);

  // Sequencer, arbiter state and bank storage share one clocked process so
  // the asynchronous clear reaches every register in the same place.
  always_ff @(posedge Cp or negedge nCLR) begin
    if (!nCLR) begin
      state     <= IDLE;
      gntA      <= 1'b0;
      gntB      <= 1'b0;
      done      <= 1'b0;
      last      <= 1'b1;
      hold_addr <= '0;
      hold_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= CAPTURE;
            gntA      <= ~win_b;
            gntB      <= win_b;
            last      <= win_b;
            hold_addr <= win_b ? addrB : addrA;
            hold_data <= win_b ? dataB : dataA;
          end
        end
        CAPTURE: begin
          // Requests are ignored here; the latched write lands in the bank.
          bank[hold_addr] <= hold_data;
          gntA            <= 1'b0;
          gntB            <= 1'b0;
          done            <= 1'b1;
          state           <= COMMIT;
        end
        COMMIT: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gntA  <= 1'b0;
          gntB  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_arbiter
//
// Self-checking bench for dff_bank_arbiter: a table of cycle vectors after
// reset, hand-written reset / ordering / idle sequences, and a randomized
// phase compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_dff_bank_arbiter;

  localparam int WIDTH = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic             Cp = 1'b0;
  logic             nCLR = 1'b0;
  logic             reqA = 1'b0;
  logic [AW-1:0]    addrA = '0;
  logic [WIDTH-1:0] dataA = '0;
  logic             reqB = 1'b0;
  logic [AW-1:0]    addrB = '0;
  logic [WIDTH-1:0] dataB = '0;
  logic             gntA;
  logic             gntB;
  logic             done;
  logic             busy;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] rd_data;

  int vec_count  = 0;
  int miss_count = 0;

  dff_bank_arbiter #(.WIDTH(WIDTH), .AW(AW)) dut (
    .Cp      (Cp),
    .nCLR    (nCLR),
    .reqA    (reqA),
    .addrA   (addrA),
    .dataA   (dataA),
    .reqB    (reqB),
    .addrB   (addrB),
    .dataB   (dataB),
    .gntA    (gntA),
    .gntB    (gntB),
    .done    (done),
    .busy    (busy),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 Cp = ~Cp;

  typedef struct {
    logic             ra;
    logic [AW-1:0]    aa;
    logic [WIDTH-1:0] da;
    logic             rb;
    logic [AW-1:0]    ab;
    logic [WIDTH-1:0] db;
    logic [AW-1:0]    rd;
    logic             e_ga;
    logic             e_gb;
    logic             e_done;
    logic             e_busy;
    logic [WIDTH-1:0] e_rd;
  } vec_t;

  vec_t tbl[16];

  // Reference model state for the randomized phase
  logic [WIDTH-1:0] m_bank [DEPTH];
  logic             m_last_b;
  bit               m_win_b;
  int               g_edge;
  int               next_free;
  logic [AW-1:0]    p_addr;
  logic [WIDTH-1:0] p_data;

  // Drive all request-side and read inputs in one go
  task automatic applyStimulus(input logic ra, input logic [AW-1:0] aa, input logic [WIDTH-1:0] da,
                               input logic rb, input logic [AW-1:0] ab, input logic [WIDTH-1:0] db,
                               input logic [AW-1:0] rd);
    reqA    = ra;
    addrA   = aa;
    dataA   = da;
    reqB    = rb;
    addrB   = ab;
    dataB   = db;
    rd_addr = rd;
  endtask

  // Single compare, counted and reported on failure
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic e_ga, input logic e_gb, input logic e_done,
                          input logic e_busy, input logic [WIDTH-1:0] e_rd);
    checkOutput({tag, " gntA"}, 32'(gntA), 32'(e_ga));
    checkOutput({tag, " gntB"}, 32'(gntB), 32'(e_gb));
    checkOutput({tag, " done"}, 32'(done), 32'(e_done));
    checkOutput({tag, " busy"}, 32'(busy), 32'(e_busy));
    checkOutput({tag, " rd_data"}, 32'(rd_data), 32'(e_rd));
  endtask

  task automatic stepCycle();
    @(posedge Cp);
    @(negedge Cp);
  endtask

  // Full write by a single requester, checking grant, done and idle cycles
  task automatic runWrite(input string tag, input bit use_b, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] old_val);
    if (use_b) applyStimulus(1'b0, '0, '0, 1'b1, a, d, a);
    else       applyStimulus(1'b1, a, d, 1'b0, '0, '0, a);
    stepCycle();
    checkAll({tag, " grant"}, !use_b, use_b, 1'b0, 1'b1, old_val);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, a);
    stepCycle();
    checkAll({tag, " done"}, 1'b0, 1'b0, 1'b1, 1'b1, d);
    stepCycle();
    checkAll({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  // Assert reset at a falling edge for n cycles, release on a falling edge
  task automatic applyReset(input int n);
    nCLR = 1'b0;
    repeat (n) @(negedge Cp);
    nCLR = 1'b1;
  endtask

  initial begin
    // Contention from reset: A,B,A,B; then a lone write by A to entry 2
    tbl[0]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[1]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5};
    tbl[2]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    tbl[3]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0};
    tbl[4]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[5]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
    tbl[6]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5};
    tbl[7]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[8]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
    tbl[9]  = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
    tbl[10] = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3};
    tbl[11] = '{1'b1, 2'd0, 4'h5, 1'b1, 2'd1, 4'h3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
    tbl[12] = '{1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 4'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0};
    tbl[13] = '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    tbl[14] = '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA};
    tbl[15] = '{1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};

    @(negedge Cp);
    applyReset(2);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].ra, tbl[i].aa, tbl[i].da, tbl[i].rb, tbl[i].ab, tbl[i].db, tbl[i].rd);
      stepCycle();
      checkAll($sformatf("row%0d", i), tbl[i].e_ga, tbl[i].e_gb, tbl[i].e_done, tbl[i].e_busy, tbl[i].e_rd);
    end

    // Reset with both requests high; bank currently holds 5,3,A,0
    applyStimulus(1'b1, 2'd0, 4'h9, 1'b1, 2'd1, 4'h6, 2'd0);
    nCLR = 1'b0;
    #1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      #1;
      checkOutput($sformatf("rst rd%0d", a), 32'(rd_data), 32'h0);
    end
    checkAll("rst now", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    rd_addr = 2'd0;
    @(negedge Cp);
    checkAll("rst cyc1", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge Cp);
    checkAll("rst cyc2", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    nCLR = 1'b1;
    stepCycle();
    checkAll("rst first", 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 2'd0);
    stepCycle();
    checkAll("rst first done", 1'b0, 1'b0, 1'b1, 1'b1, 4'h9);
    stepCycle();
    checkAll("rst first idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'h9);

    // Same-address ordering on entry 3
    runWrite("same A", 1'b0, 2'd3, 4'h1, 4'h0);
    runWrite("same B", 1'b1, 2'd3, 4'hF, 4'h1);

    // Reset pulse while a B write of 7 to entry 1 is in CAPTURE
    applyStimulus(1'b0, '0, '0, 1'b1, 2'd1, 4'h7, 2'd1);
    stepCycle();
    checkAll("mid grant", 1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 2'd3);
    nCLR = 1'b0;
    #1;
    checkAll("mid rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    #2;
    nCLR = 1'b1;
    rd_addr = 2'd1;
    stepCycle();
    checkAll("mid after", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    applyStimulus(1'b1, 2'd2, 4'h6, 1'b1, 2'd1, 4'h7, 2'd2);
    stepCycle();
    checkAll("mid tie", 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 2'd2);
    stepCycle();
    checkAll("mid tie done", 1'b0, 1'b0, 1'b1, 1'b1, 4'h6);
    stepCycle();

    // Idle stability: bank expected {0,0,6,0}
    for (int c = 0; c < 10; c++) begin
      logic [WIDTH-1:0] e;
      rd_addr = AW'(c % DEPTH);
      e = (c % DEPTH == 2) ? 4'h6 : 4'h0;
      stepCycle();
      checkAll($sformatf("idle%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, e);
    end

    // Randomized phase against the transaction-level model
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0);
    applyReset(1);
    for (int a = 0; a < DEPTH; a++) m_bank[a] = '0;
    m_last_b  = 1'b1;
    m_win_b   = 1'b0;
    g_edge    = -10;
    next_free = 0;
    p_addr    = '0;
    p_data    = '0;
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, AW'($urandom), WIDTH'($urandom),
                    $urandom_range(0, 9) < 6, AW'($urandom), WIDTH'($urandom), AW'($urandom));
      @(posedge Cp);
      // A granted write becomes visible one edge after its grant
      if (n == g_edge + 1) m_bank[p_addr] = p_data;
      // A request is only sampled once three edges have passed since the last grant
      if (n >= next_free && (reqA || reqB)) begin
        if (reqA && reqB) m_win_b = !m_last_b;
        else              m_win_b = reqB;
        m_last_b  = m_win_b;
        g_edge    = n;
        next_free = n + 3;
        p_addr    = m_win_b ? addrB : addrA;
        p_data    = m_win_b ? dataB : dataA;
      end
      @(negedge Cp);
      checkAll($sformatf("rand%0d", n), (n == g_edge) && !m_win_b, (n == g_edge) && m_win_b,
               n == g_edge + 1, (n == g_edge) || (n == g_edge + 1), m_bank[rd_addr]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
